iz_rg_array: RTL and testbench
==============================

# iz_rg_array

Time-multiplexed array of N Izhikevich spiking neurons sharing one fixed-point update datapath; the parametrised successor to the single-neuron IZ_RG core. Each accepted `step` advances every neuron by one Euler step, one neuron per clock, with a per-neuron mode preset, refractory current gating and saturating spike counters. Sits behind the tile wrapper, which drives currents/modes and monitors one channel.

## Interface
- `N`, 4: neuron count (≥2)
- `DW`, 8: signed width of v and u
- `IW`, 5: unsigned current width per neuron
- `CNT_W`, 8: spike counter width
- `REFRAC`, 2: refractory length in steps (0 disables)
- `V_PEAK`, 30: spike threshold
- `clk` in 1: clock
- `rst` in 1: reset; one clock, synchronous, active-high
- `step` in 1: request one step; accepted only when `busy`=0
- `i_in` in N*IW: currents, neuron k at [k*IW +: IW]; latched on accept
- `mode` in N*3: mode per neuron; latched on accept
- `mon_sel` in clog2(N): monitored neuron
- `cnt_clr` in 1: clear all spike counters
- `busy` out 1: step in progress
- `done` out 1: one-cycle pulse, step complete
- `spike` out N: spike flags of last completed step
- `v_out`, `u_out` out DW signed: v/u of `mon_sel`
- `cnt_out` out CNT_W: spike count of `mon_sel`

## Operation
- Presets (a_shift, c, d; b = 1/4 for all): 0 RS (6, −65, 8); 1 IB (6, −55, 4); 2 CH (6, −50, 2); 3 FS (3, −65, 2); modes 4–7 alias mode−4. Mode change applies from next step; v/u untouched.
- Arithmetic signed, width 2*DW+8, `>>>` arithmetic floor shift. I_eff = refractory≠0 ? 0 : zero-extended I.
- dv = ((v*v*41) >>> 10) + 5v + 140 − u + I_eff; v_raw = v + dv.
- du = ((v >>> 2) − u) >>> a_shift; u_raw = u + du (old v used).
- v_raw ≥ V_PEAK (full width, pre-saturation): v ← c, u ← sat(u_raw + d), spike[k]=1, refractory ← REFRAC, counter[k] +1.
- Else v ← sat(v_raw), u ← sat(u_raw); refractory decrements if nonzero.
- sat clamps to [−2^(DW−1), 2^(DW−1)−1]. Counters saturate at 2^CNT_W−1.
- `cnt_clr` clears all counters; beats a coincident increment.
- Reset: all v = −65, u = −17, refractory 0, counters 0, `busy`=`done`=0, `spike`=0, `v_out`=−65, `u_out`=−17, `cnt_out`=0. Internal latched modes 0, currents 0.

## Timing
- FSM: IDLE → RUN (index 0..N−1) → IDLE.
- `step` sampled at edge e0 with `busy`=0: latch `i_in`/`mode`, `busy`←1.
- Neuron k state written at edge e0+k+1.
- Edge e0+N: last write, `spike` ← flags of this step (all bits together), `done`←1 for one cycle, `busy`←0.
- `step` while `busy`=1 (including edge e0+N) ignored, not queued. Max rate: one step per N+1 cycles.
- `v_out`/`u_out`/`cnt_out` registered every cycle from `mon_sel`: one-cycle latency; reflect writes of the previous edge.
- `rst` mid-step aborts: no `done`, all state to reset values.

## Test plan
- Reset: `v_out`=−65 (0xBF), `u_out`=−17 (0xEF), `busy`=0, `spike`=0, `cnt_out`=0.
- Mode 0, I=0, one step: `busy` high 4 cycles, single `done`; every neuron v=−64, u=−17.
- Mode 0, neuron 1 I=10, others 0: neuron 1 v=−54, u=−17; `mon_sel`=1 shows it one cycle after `done`.
- Mode 0, I=31 held: first spike → v=−65, u=pre+8, `spike` bit set that step only, `cnt_out`+1; next 2 steps evolve as I=0.
- `step` held high continuously: `done` every 5 cycles (N=4); pulse at e0+N ignored; `rst` at e0+2 → no `done`, reset values.
- Counter: force 260 spikes → `cnt_out` stays 255; `cnt_clr` coincident with spike → 0.

Source files
------------

// File: rtl/iz_rg_array.sv
`default_nettype none
// ============================================================================
// Module   : iz_rg_array
// Purpose  : Time-multiplexed array of N Izhikevich neurons sharing a single
//            fixed-point Euler-step datapath. One accepted step updates
//            neuron 0..N-1 on consecutive clocks. Each neuron has a mode preset,
//            refractory current gating and a saturating spike counter.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            step          - start one step (accepted only while idle)
//            i_in, mode    - per-neuron current / mode, latched on accept
//            mon_sel       - neuron shown on v_out / u_out / cnt_out
//            cnt_clr       - clear every spike counter
//            busy, done    - step in progress / one-cycle completion pulse
//            spike         - spike flags of the last completed step
//            v_out, u_out  - monitored neuron state (registered)
//            cnt_out       - monitored neuron spike count (registered)
// Revision : 1.0 - initial release
// ============================================================================
module iz_rg_array #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int IW     = 5,
    parameter int CNT_W  = 8,
    parameter int REFRAC = 2,
    parameter int V_PEAK = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step,
    input  logic [N*IW-1:0]      i_in,
    input  logic [N*3-1:0]       mode,
    input  logic [$clog2(N)-1:0] mon_sel,
    input  logic                 cnt_clr,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         spike,
    output logic signed [DW-1:0] v_out,
    output logic signed [DW-1:0] u_out,
    output logic [CNT_W-1:0]     cnt_out
);

    localparam int c_IDXW = $clog2(N);
    localparam int c_PW   = 2*DW + 8;
    localparam int c_RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic [c_IDXW-1:0]      c_LAST    = c_IDXW'(N - 1);
    localparam logic signed [DW-1:0]   c_V_RST   = DW'(-65);
    localparam logic signed [DW-1:0]   c_U_RST   = DW'(-17);
    localparam logic signed [c_PW-1:0] c_SAT_MAX = c_PW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [c_PW-1:0] c_SAT_MIN = c_PW'(-(1 <<< (DW - 1)));
    localparam logic signed [c_PW-1:0] c_K41     = c_PW'(41);
    localparam logic signed [c_PW-1:0] c_K5      = c_PW'(5);
    localparam logic signed [c_PW-1:0] c_K140    = c_PW'(140);
    localparam logic signed [c_PW-1:0] c_VPK     = c_PW'(V_PEAK);
    localparam logic [c_RW-1:0]        c_REF_LEN = c_RW'(REFRAC);
    localparam logic [CNT_W-1:0]       c_CNT_MAX = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_start;
    logic                    w_run;
    logic                    w_last;

    logic [c_IDXW-1:0]       r_idx;
    logic signed [DW-1:0]    r_v     [N];
    logic signed [DW-1:0]    r_u     [N];
    logic [c_RW-1:0]         r_ref   [N];
    logic [CNT_W-1:0]        r_cnt   [N];
    logic [IW-1:0]           r_i     [N];
    logic [1:0]              r_mode  [N];
    logic [N-1:0]            r_spk_acc;
    logic [N-1:0]            w_spk_now;

    logic signed [c_PW-1:0]  w_v;
    logic signed [c_PW-1:0]  w_u;
    logic signed [c_PW-1:0]  w_ieff;
    logic signed [c_PW-1:0]  w_vsq;
    logic signed [c_PW-1:0]  w_vraw;
    logic signed [c_PW-1:0]  w_du;
    logic signed [c_PW-1:0]  w_uraw;
    logic signed [c_PW-1:0]  w_d;
    logic signed [DW-1:0]    w_c;
    logic [2:0]              w_ashift;
    logic                    w_fire;
    logic signed [DW-1:0]    w_v_new;
    logic signed [DW-1:0]    w_u_new;
    logic [c_IDXW-1:0]       w_mon_idx;
    logic                    w_unused_mode;

    function automatic logic signed [DW-1:0] sat(input logic signed [c_PW-1:0] x);
        if (x > c_SAT_MAX) return c_SAT_MAX[DW-1:0];
        if (x < c_SAT_MIN) return c_SAT_MIN[DW-1:0];
        return x[DW-1:0];
    endfunction

    // Modes 4..7 alias 0..3, so the top mode bit is never stored.
    always_comb begin
        w_unused_mode = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_unused_mode = w_unused_mode ^ mode[3*k + 2];
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (step) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (r_idx == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_RUN);

    // ------------------------------------------------- shared datapath
    always_comb begin
        w_v    = c_PW'(r_v[r_idx]);
        w_u    = c_PW'(r_u[r_idx]);
        // Current is gated off while the neuron is refractory.
        w_ieff = (r_ref[r_idx] != '0) ? '0 : {{(c_PW-IW){1'b0}}, r_i[r_idx]};

        case (r_mode[r_idx])
            2'd0:    begin w_ashift = 3'd6; w_c = DW'(-65); w_d = c_PW'(8); end
            2'd1:    begin w_ashift = 3'd6; w_c = DW'(-55); w_d = c_PW'(4); end
            2'd2:    begin w_ashift = 3'd6; w_c = DW'(-50); w_d = c_PW'(2); end
            default: begin w_ashift = 3'd3; w_c = DW'(-65); w_d = c_PW'(2); end
        endcase

        // 0.04*v^2 approximated as 41/1024, floor via arithmetic shift.
        w_vsq  = (w_v * w_v * c_K41) >>> 10;
        w_vraw = w_v + w_vsq + (w_v * c_K5) + c_K140 - w_u + w_ieff;
        // b = 1/4 for every preset; a = 2^-a_shift. Uses the old v.
        w_du   = ((w_v >>> 2) - w_u) >>> w_ashift;
        w_uraw = w_u + w_du;

        // Threshold is tested on the unsaturated v so large jumps still fire.
        w_fire  = (w_vraw >= c_VPK);
        w_v_new = w_fire ? w_c : sat(w_vraw);
        w_u_new = w_fire ? sat(w_uraw + w_d) : sat(w_uraw);

        w_spk_now        = r_spk_acc;
        w_spk_now[r_idx] = w_fire;
    end

    // ------------------------------------------------- neuron state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_spk_acc <= '0;
            spike     <= '0;
            done      <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_v[k]    <= c_V_RST;
                r_u[k]    <= c_U_RST;
                r_ref[k]  <= '0;
                r_cnt[k]  <= '0;
                r_i[k]    <= '0;
                r_mode[k] <= 2'd0;
            end
        end else begin
            done <= 1'b0;

            if (w_start) begin
                r_idx     <= '0;
                r_spk_acc <= '0;
                for (int k = 0; k < N; k++) begin
                    r_i[k]    <= i_in[k*IW +: IW];
                    r_mode[k] <= mode[k*3 +: 2];
                end
            end

            if (w_run) begin
                r_v[r_idx] <= w_v_new;
                r_u[r_idx] <= w_u_new;
                if (w_fire)                   r_ref[r_idx] <= c_REF_LEN;
                else if (r_ref[r_idx] != '0)  r_ref[r_idx] <= r_ref[r_idx] - 1'b1;
                r_spk_acc <= w_spk_now;
                r_idx     <= r_idx + 1'b1;
                // All spike flags become visible together with the last write.
                if (w_last) begin
                    spike <= w_spk_now;
                    done  <= 1'b1;
                end
            end

            // Clear has priority over a coincident increment.
            for (int k = 0; k < N; k++) begin
                if (cnt_clr) begin
                    r_cnt[k] <= '0;
                end else if (w_run && w_fire && (r_idx == c_IDXW'(k)) &&
                             (r_cnt[k] != c_CNT_MAX)) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------- monitor channel
    generate
        if ((1 << c_IDXW) == N) begin : g_mon_direct
            assign w_mon_idx = mon_sel;
        end else begin : g_mon_clamp
            assign w_mon_idx = (mon_sel > c_LAST) ? c_LAST : mon_sel;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v_out   <= c_V_RST;
            u_out   <= c_U_RST;
            cnt_out <= '0;
        end else begin
            v_out   <= r_v[w_mon_idx];
            u_out   <= r_u[w_mon_idx];
            cnt_out <= r_cnt[w_mon_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iz_rg_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_iz_rg_array
// Purpose  : Self-checking bench for iz_rg_array. Stimulus computes expected
//            step results with an integer reference model and queues them;
//            a monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iz_rg_array;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int IW     = 5;
    localparam int CNT_W  = 8;
    localparam int REFRAC = 2;
    localparam int V_PEAK = 30;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 step;
    logic [N*IW-1:0]      i_in;
    logic [N*3-1:0]       mode;
    logic [$clog2(N)-1:0] mon_sel;
    logic                 cnt_clr;
    logic                 busy;
    logic                 done;
    logic [N-1:0]         spike;
    logic signed [DW-1:0] v_out;
    logic signed [DW-1:0] u_out;
    logic [CNT_W-1:0]     cnt_out;

    always #5 clk = ~clk;

    iz_rg_array #(
        .N(N), .DW(DW), .IW(IW), .CNT_W(CNT_W), .REFRAC(REFRAC), .V_PEAK(V_PEAK)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .i_in(i_in), .mode(mode),
        .mon_sel(mon_sel), .cnt_clr(cnt_clr), .busy(busy), .done(done),
        .spike(spike), .v_out(v_out), .u_out(u_out), .cnt_out(cnt_out)
    );

    typedef struct {
        logic [N-1:0] spk;
        int           v;
        int           u;
        int           cnt;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         pend;
    bit           chk_pending = 1'b0;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           busy_cnt = 0;
    int           done_cnt = 0;
    logic [N-1:0] last_spk;

    // Reference model state
    int mv[N], mu[N], mref[N], mcnt[N], mi[N], mmode[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------ reference model
    function automatic int sat(input int x);
        int lo = -(1 << (DW - 1));
        int hi = (1 << (DW - 1)) - 1;
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = -65; mu[k] = -17; mref[k] = 0; mcnt[k] = 0; mi[k] = 0; mmode[k] = 0;
        end
    endfunction

    function automatic void neuron_next(input int k, output int nv, output int nu,
                                        output bit fire);
        int v  = mv[k];
        int u  = mu[k];
        int ie = (mref[k] != 0) ? 0 : mi[k];
        int m  = mmode[k] % 4;
        int a  = (m == 3) ? 3 : 6;
        int c  = (m == 1) ? -55 : ((m == 2) ? -50 : -65);
        int d  = (m == 0) ? 8 : ((m == 1) ? 4 : 2);
        int vr = v + ((v * v * 41) >>> 10) + 5 * v + 140 - u + ie;
        int ur = u + (((v >>> 2) - u) >>> a);
        fire = (vr >= V_PEAK);
        nv   = fire ? c : sat(vr);
        nu   = fire ? sat(ur + d) : sat(ur);
    endfunction

    function automatic logic [N-1:0] model_step();
        logic [N-1:0] s = '0;
        int nv, nu;
        bit f;
        for (int k = 0; k < N; k++) begin
            neuron_next(k, nv, nu, f);
            mv[k] = nv;
            mu[k] = nu;
            s[k]  = f;
            if (f) begin
                mref[k] = REFRAC;
                if (mcnt[k] < (1 << CNT_W) - 1) mcnt[k]++;
            end else if (mref[k] > 0) begin
                mref[k]--;
            end
        end
        return s;
    endfunction

    task automatic latch_inputs();
        for (int k = 0; k < N; k++) begin
            mi[k]    = int'(i_in[k*IW +: IW]);
            mmode[k] = int'(mode[k*3 +: 3]);
        end
    endtask

    // Record the expected outcome of a step that the DUT accepts at the next edge.
    task automatic issue(input bit clr_last);
        exp_t e;
        latch_inputs();
        e.spk = model_step();
        if (clr_last) for (int k = 0; k < N; k++) mcnt[k] = 0;
        e.v   = mv[mon_sel];
        e.u   = mu[mon_sel];
        e.cnt = mcnt[mon_sel];
        e.cyc = cyc + 1 + N;
        last_spk = e.spk;
        sb.push_back(e);
    endtask

    // ------------------------------------------------ monitor
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (chk_pending) begin
            chk("v_out", int'(v_out), pend.v);
            chk("u_out", int'(u_out), pend.u);
            chk("cnt_out", int'(cnt_out), pend.cnt);
            chk_pending = 1'b0;
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                pend = sb.pop_front();
                chk("spike", int'(spike), int'(pend.spk));
                chk("done_cycle", cyc, pend.cyc);
                chk_pending = 1'b1;
            end
        end
    end

    // ------------------------------------------------ stimulus helpers
    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || chk_pending) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: got %0d outstanding results expected 0", sb.size());
            sb.delete();
            chk_pending = 1'b0;
        end
    endtask

    task automatic do_step(input bit clr_last);
        step = 1'b1;
        issue(clr_last);
        @(negedge clk);
        step = 1'b0;
        if (clr_last) begin
            // Pulse clear so it lands on the edge that writes the last neuron.
            repeat (N - 1) @(negedge clk);
            cnt_clr = 1'b1;
            @(negedge clk);
            cnt_clr = 1'b0;
        end
        wait_idle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sb.delete();
        chk_pending = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_all(input int cur, input int md);
        for (int k = 0; k < N; k++) begin
            i_in[k*IW +: IW] = IW'(cur);
            mode[k*3 +: 3]   = 3'(md);
        end
    endtask

    // ------------------------------------------------ watchdog
    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------ main sequence
    initial begin
        int d0, tally, next_acc;
        bit fired;

        rst = 1'b1; step = 1'b0; cnt_clr = 1'b0; mon_sel = '0;
        i_in = '0; mode = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_spike", int'(spike), 0);
        chk("rst_v_out", int'(v_out), -65);
        chk("rst_u_out", int'(u_out), -17);
        chk("rst_cnt_out", int'(cnt_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, no current: one step, busy N cycles, single done
        set_all(0, 0);
        mon_sel = 2;
        busy_cnt = 0;
        done_cnt = 0;
        do_step(1'b0);
        chk("busy_cycles", busy_cnt, N);
        chk("done_pulses", done_cnt, 1);
        chk("rest_v", int'(v_out), -64);
        chk("rest_u", int'(u_out), -17);

        // Neuron 1 with I=10 from reset
        pulse_reset();
        set_all(0, 0);
        i_in[1*IW +: IW] = IW'(10);
        mon_sel = 1;
        do_step(1'b0);
        chk("i10_v", int'(v_out), -54);
        chk("i10_u", int'(u_out), -17);

        // Mode 0, I=31 held on neuron 0 until the first spike, then 2 refractory steps
        pulse_reset();
        set_all(0, 0);
        i_in[0 +: IW] = IW'(31);
        mon_sel = 0;
        fired = 1'b0;
        for (int s = 0; s < 30 && !fired; s++) begin
            do_step(1'b0);
            fired = last_spk[0];
        end
        chk("first_spike_v", int'(v_out), -65);
        chk("first_spike_cnt", int'(cnt_out), 1);
        do_step(1'b0);
        do_step(1'b0);

        // Randomized steps
        for (int s = 0; s < 40; s++) begin
            for (int k = 0; k < N; k++) begin
                i_in[k*IW +: IW] = IW'($urandom_range(0, (1 << IW) - 1));
                mode[k*3 +: 3]   = 3'($urandom_range(0, 7));
            end
            mon_sel = $clog2(N)'($urandom_range(0, N - 1));
            if ($urandom_range(0, 9) == 0) begin
                cnt_clr = 1'b1;
                @(negedge clk);
                cnt_clr = 1'b0;
                for (int k = 0; k < N; k++) mcnt[k] = 0;
            end
            do_step(1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // step held high: acceptance only every N+1 cycles
        for (int k = 0; k < N; k++) i_in[k*IW +: IW] = IW'($urandom_range(0, 31));
        mon_sel = $clog2(N)'($urandom_range(0, N - 1));
        step = 1'b1;
        next_acc = cyc + 1;
        for (int t = 0; t < 32; t++) begin
            if (cyc + 1 >= next_acc) begin
                issue(1'b0);
                next_acc = cyc + 1 + N + 1;
            end
            @(negedge clk);
        end
        step = 1'b0;
        wait_idle();

        // Reset in the middle of a step: no done, everything back to reset
        mon_sel = 1;
        d0 = done_cnt;
        step = 1'b1;
        issue(1'b0);
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        chk_pending = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_spike", int'(spike), 0);
        chk("abort_v_out", int'(v_out), -65);
        chk("abort_u_out", int'(u_out), -17);
        chk("abort_cnt_out", int'(cnt_out), 0);

        // Counter saturation: FS mode, maximum current, 260+ spikes on neuron 0
        set_all(31, 3);
        mon_sel = 0;
        tally = 0;
        for (int s = 0; s < 3000 && tally < 260; s++) begin
            do_step(1'b0);
            if (last_spk[0]) tally++;
        end
        chk("cnt_saturated", int'(cnt_out), (1 << CNT_W) - 1);

        // Clear coincident with a spike of the last neuron
        mon_sel = $clog2(N)'(N - 1);
        fired = 1'b0;
        for (int s = 0; s < 30 && !fired; s++) begin
            int nv, nu;
            bit f;
            latch_inputs();
            neuron_next(N - 1, nv, nu, f);
            if (f) begin
                do_step(1'b1);
                fired = 1'b1;
            end else begin
                do_step(1'b0);
            end
        end
        chk("clr_beats_inc", int'(cnt_out), 0);

        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
